// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, valid/ready on both sides.
// Divide-by-zero and signed overflow resolve in the accept cycle.
module riscv_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;

    logic              a_signed, b_signed, sa, sb, neg_in;
    logic [XLEN-1:0]   abs_a, abs_b, fast_res;
    logic              div_zero, div_ovf, accept;

    // Operand decode at the accept edge
    always_comb begin
        a_signed = (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op[2] & ~i_op[0]);
        b_signed = (i_op == OP_MULH) | (i_op[2] & ~i_op[0]);
        sa       = a_signed & i_a[XLEN-1];
        sb       = b_signed & i_b[XLEN-1];
        abs_a    = cond_neg(i_a, sa);
        abs_b    = cond_neg(i_b, sb);
        case (i_op)
            OP_MULH:   neg_in = sa ^ sb;
            OP_MULHSU: neg_in = sa;
            OP_DIV:    neg_in = sa ^ sb;
            OP_REM:    neg_in = sa;
            default:   neg_in = 1'b0;
        endcase
        div_zero = i_op[2] & (i_b == '0);
        div_ovf  = i_op[2] & ~i_op[0] & (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);
        if (div_zero)
            fast_res = i_op[1] ? i_a : '1;
        else
            fast_res = i_op[1] ? '0 : i_a;
        accept = i_valid & (state == S_IDLE);
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_diff, div_rem, mul_res, div_res, calc_res;
    logic              div_ge;

    // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first)
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_trial >= {1'b0, b_q};
        div_diff  = div_trial[XLEN-1:0] - b_q;
        div_rem   = div_ge ? div_diff : div_trial[XLEN-1:0];
        div_next  = {div_rem, acc[XLEN-2:0], div_ge};
        acc_next  = op_q[2] ? div_next : mul_next;
        prod      = cond_neg_wide(acc_next, neg_q);
        mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_res   = cond_neg(op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0], neg_q);
        calc_res  = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (div_zero | div_ovf) begin
                            result_q <= fast_res;
                            state    <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result_q <= calc_res;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_q  <= i_op;
            neg_q <= neg_in;
            b_q   <= abs_b;
            acc   <= {{XLEN{1'b0}}, abs_a};
        end else if (state == S_CALC) begin
            acc <= acc_next;
        end
    end

    assign o_ready  = (state == S_IDLE);
    assign o_valid  = (state == S_DONE);
    assign o_busy   = (state != S_IDLE);
    assign o_result = result_q;
    assign o_zero   = (state == S_DONE) & (result_q == '0);

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed RV32M cases plus randomized traffic
// against an arithmetic reference model.
module tb_riscv_muldiv;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    riscv_muldiv #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_zero(o_zero), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // RV32M semantics computed with 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0] p;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Issue one request from IDLE, wait (bounded) for the result, then retire it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 3'($urandom);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        res = o_result; z = o_zero;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        checks++;
        if ({o_valid, o_ready, o_busy, o_zero} !== 4'b0100 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset: valid/ready/busy/zero=%b result=%h, required 0100 and 00000000",
                     {o_valid, o_ready, o_busy, o_zero}, o_result);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z; int lat;
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3};
        logic [31:0] as  [5] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006, 32'hFFFF_FFFF, 32'h4000_0000};
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], r, z, lat);
            checks++;
            if (r !== exp[i] || lat != 33) begin
                errors++;
                $display("FAIL mul[%0d] op=%0d: result=%h lat=%0d, required %h lat=33", i, ops[i], r, lat, exp[i]);
            end
        end
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL retire: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_div();
        logic [31:0] r; logic z; int lat;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], 32'd2, r, z, lat);
            checks++;
            if (r !== exp[i] || lat != 33) begin
                errors++;
                $display("FAIL div[%0d] op=%0d: result=%h lat=%0d, required %h lat=33", i, ops[i], r, lat, exp[i]);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [31:0] r; logic z; int lat;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, z, lat);
            checks++;
            if (r !== exp[i] || lat != 1 || z !== (exp[i] == 0)) begin
                errors++;
                $display("FAIL fast[%0d] op=%0d: result=%h zero=%b lat=%0d, required %h zero=%b lat=1",
                         i, ops[i], r, z, lat, exp[i], exp[i] == 0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int lat; int bad;
        i_op = 3'd3; i_a = 32'h8000_0000; i_b = 32'h8000_0000; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        r = o_result;
        checks++;
        if (r !== 32'h4000_0000 || lat != 33) begin
            errors++;
            $display("FAIL bp_result: result=%h lat=%0d, required 40000000 lat=33", r, lat);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            i_a = $urandom; i_b = $urandom;
            @(posedge i_clk); #1;
            if (o_result !== r || o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_retire: ready=%b valid=%b busy=%b, required 1 0 0", o_ready, o_valid, o_busy);
        end
    endtask

    task automatic test_ignore_valid();
        int lat; int bad; logic [31:0] r;
        i_op = 3'd1; i_a = 32'h1234_5678; i_b = 32'hFEDC_BA98; i_valid = 1'b1;
        @(posedge i_clk); #1;
        bad = 0; lat = 1;
        while (!o_valid && lat < 100) begin
            if (o_ready !== 1'b0) bad++;
            i_a = $urandom; i_b = $urandom; i_op = 3'($urandom);
            @(posedge i_clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        r = o_result;
        checks++;
        if (bad != 0 || lat != 33 || r !== ref_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98)) begin
            errors++;
            $display("FAIL ignore_valid: result=%h lat=%0d ready_high=%0d, required %h lat=33 ready_high=0",
                     r, lat, bad, ref_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98));
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_retire: ready=%b busy=%b, required 1 0", o_ready, o_busy);
        end
    endtask

    task automatic test_abort_reset();
        logic [31:0] r; logic z; int lat;
        i_op = 3'd0; i_a = 32'hDEAD_BEEF; i_b = 32'h0000_1235; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (15) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL abort: valid=%b ready=%b busy=%b result=%h, required 0 1 0 00000000",
                     o_valid, o_ready, o_busy, o_result);
        end
        run_op(3'd0, 32'd3, 32'd4, r, z, lat);
        checks++;
        if (r !== 32'd12 || lat != 33 || z !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: result=%h lat=%0d, required 0000000c lat=33", r, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, e; logic z; logic [2:0] op; int lat, el;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 3));
                default: ;
            endcase
            e = ref_op(op, a, b);
            el = ref_lat(op, a, b);
            run_op(op, a, b, r, z, lat);
            checks++;
            if (r !== e || lat != el || z !== (e == 0)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h zero=%b lat=%0d, required %h zero=%b lat=%0d",
                         i, op, a, b, r, z, lat, e, e == 0, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_ignore_valid();
        test_abort_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
